// File: rtl/fft_frame_ctrl.sv
// ============================================================================
// Module   : fft_frame_ctrl
// Purpose  : Symbol-level scheduler in front of a single-delay-feedback FFT.
//            Admits one slot of NSYM symbols and reads each N-sample symbol
//            from an FWFT buffer as one gap-free burst. Feeds the FFT inputs
//            and bounds the number of symbols in flight. Also tags the FFT
//            output stream with start/end of symbol and a symbol index.
// Ports    : clk, rst (async, active-low)
//            slot_start, frm_avail, buf_re/buf_im  -> upstream / control
//            rd_en                                 -> buffer pop strobe
//            fft_on, fft_di_en, fft_di_re/im       -> FFT input side
//            fft_do_en                             <- FFT output enable
//            out_sop, out_eop, out_sym             -> output tagging
//            busy, slot_done, err                  -> status
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fft_frame_ctrl #(
  parameter int N            = 128,
  parameter int NSYM         = 14,
  parameter int MAX_INFLIGHT = 2,
  parameter int WIDTH        = 16,
  localparam int OW          = (NSYM > 1) ? $clog2(NSYM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slot_start,
  input  logic             frm_avail,
  input  logic [WIDTH-1:0] buf_re,
  input  logic [WIDTH-1:0] buf_im,
  output logic             rd_en,
  output logic             fft_on,
  output logic             fft_di_en,
  output logic [WIDTH-1:0] fft_di_re,
  output logic [WIDTH-1:0] fft_di_im,
  input  logic             fft_do_en,
  output logic             out_sop,
  output logic             out_eop,
  output logic [OW-1:0]    out_sym,
  output logic             busy,
  output logic             slot_done,
  output logic             err
);

  localparam int CW = $clog2(N);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int SW = $clog2(NSYM + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   bcnt;
  logic [CW-1:0]   out_cnt;
  logic [IW-1:0]   inflight;
  logic [IW-1:0]   inflight_nxt;
  logic [SW-1:0]   sym_issued;
  logic [SW-1:0]   issued_nxt;
  logic [SW-1:0]   sym_out;
  logic            out_act;
  logic            burst_first;
  logic            burst_last;
  logic            inc;
  logic            dec;
  logic            admit;

  assign rd_en       = (state == S_STREAM);
  assign busy        = (state != S_IDLE);

  // FFT output activity outside a slot is ignored entirely.
  assign out_act     = fft_do_en && busy;
  assign out_sop     = out_act && (out_cnt == '0);
  assign out_eop     = out_act && (out_cnt == CW'(N - 1));
  assign out_sym     = sym_out[OW-1:0];
  assign slot_done   = (state == S_DRAIN) && out_eop && (sym_out == SW'(NSYM - 1));

  assign burst_first = rd_en && (bcnt == '0);
  assign burst_last  = rd_en && (bcnt == CW'(N - 1));
  assign inc         = burst_first;
  assign dec         = out_eop && (inflight != '0);
  assign issued_nxt  = burst_last ? (sym_issued + SW'(1)) : sym_issued;

  // Net in-flight count after this cycle; an issue and a retirement in the
  // same cycle cancel out.
  always_comb begin
    inflight_nxt = inflight;
    if (inc && !dec) begin
      inflight_nxt = inflight + IW'(1);
    end else if (!inc && dec) begin
      inflight_nxt = inflight - IW'(1);
    end
  end

  // Admission uses the post-update counts so that a symbol retiring in this
  // cycle frees its credit for an admission decided in the same cycle.
  assign admit = frm_avail && (inflight_nxt < IW'(MAX_INFLIGHT)) &&
                 (issued_nxt < SW'(NSYM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      bcnt       <= '0;
      out_cnt    <= '0;
      inflight   <= '0;
      sym_issued <= '0;
      sym_out    <= '0;
      fft_on     <= 1'b0;
      fft_di_en  <= 1'b0;
      fft_di_re  <= '0;
      fft_di_im  <= '0;
      err        <= 1'b0;
    end else begin
      fft_di_en <= rd_en;
      fft_di_re <= buf_re;
      fft_di_im <= buf_im;
      err       <= slot_start && busy;
      inflight  <= inflight_nxt;

      // N is a power of two, so the burst counter wraps to 0 by itself
      // both at the end of a slot and between back-to-back bursts.
      if (rd_en) begin
        bcnt <= bcnt + CW'(1);
      end
      if (out_act) begin
        out_cnt <= out_cnt + CW'(1);
      end
      if (out_eop) begin
        sym_out <= sym_out + SW'(1);
      end

      case (state)
        S_IDLE: begin
          bcnt       <= '0;
          out_cnt    <= '0;
          inflight   <= '0;
          sym_issued <= '0;
          sym_out    <= '0;
          if (slot_start) begin
            state  <= S_WAIT;
            fft_on <= 1'b1;
          end
        end
        S_WAIT: begin
          if (admit) begin
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (burst_last) begin
            sym_issued <= issued_nxt;
            if (admit) begin
              state <= S_STREAM;
            end else if (issued_nxt == SW'(NSYM)) begin
              state <= S_DRAIN;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_DRAIN: begin
          if (slot_done) begin
            state  <= S_IDLE;
            fft_on <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
// ============================================================================
// Module   : tb_fft_frame_ctrl
// Purpose  : Directed testbench for fft_frame_ctrl. Two instances (credit
//            limit 2 and 1) share stimulus. Each instance drives a fixed-latency
//            FFT delay model. A negedge monitor collects per-slot event cycles.
//            The directed sequence compares them with hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fft_frame_ctrl;

  localparam int N     = 16;
  localparam int NSYM  = 3;
  localparam int WIDTH = 16;
  localparam int LAT   = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             slot_start = 1'b0;
  logic             frm_avail = 1'b0;
  logic             do_inject = 1'b0;
  logic [WIDTH-1:0] buf_re = 16'h1234;
  logic [WIDTH-1:0] buf_im = 16'h5678;

  logic             a_rd_en, a_fft_on, a_di_en, a_sop, a_eop, a_busy, a_done, a_err, a_do_en;
  logic [WIDTH-1:0] a_di_re, a_di_im;
  logic [1:0]       a_sym;
  logic             b_rd_en, b_fft_on, b_di_en, b_sop, b_eop, b_busy, b_done, b_err, b_do_en;
  logic [WIDTH-1:0] b_di_re, b_di_im;
  logic [1:0]       b_sym;
  logic [LAT-1:0]   a_pipe, b_pipe;
  logic [41:0]      a_outs;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.N(N), .NSYM(NSYM), .MAX_INFLIGHT(2), .WIDTH(WIDTH)) dut_a (
    .clk(clk), .rst(rst), .slot_start(slot_start), .frm_avail(frm_avail),
    .buf_re(buf_re), .buf_im(buf_im), .rd_en(a_rd_en), .fft_on(a_fft_on),
    .fft_di_en(a_di_en), .fft_di_re(a_di_re), .fft_di_im(a_di_im),
    .fft_do_en(a_do_en), .out_sop(a_sop), .out_eop(a_eop), .out_sym(a_sym),
    .busy(a_busy), .slot_done(a_done), .err(a_err));

  fft_frame_ctrl #(.N(N), .NSYM(NSYM), .MAX_INFLIGHT(1), .WIDTH(WIDTH)) dut_b (
    .clk(clk), .rst(rst), .slot_start(slot_start), .frm_avail(frm_avail),
    .buf_re(buf_re), .buf_im(buf_im), .rd_en(b_rd_en), .fft_on(b_fft_on),
    .fft_di_en(b_di_en), .fft_di_re(b_di_re), .fft_di_im(b_di_im),
    .fft_do_en(b_do_en), .out_sop(b_sop), .out_eop(b_eop), .out_sym(b_sym),
    .busy(b_busy), .slot_done(b_done), .err(b_err));

  assign a_outs = {a_rd_en, a_fft_on, a_di_en, a_di_re, a_di_im, a_sop, a_eop,
                   a_sym, a_busy, a_done, a_err};

  // FFT model: output enable is the input enable delayed by LAT cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_pipe <= '0;
      b_pipe <= '0;
    end else begin
      a_pipe <= {a_pipe[LAT-2:0], a_di_en};
      b_pipe <= {b_pipe[LAT-2:0], b_di_en};
    end
  end
  assign a_do_en = a_pipe[LAT-1] | do_inject;
  assign b_do_en = b_pipe[LAT-1] | do_inject;

  // ---------------------------------------------------------------- monitor
  int   cyc = 0;
  logic clr = 1'b1;
  int a_rd_cnt, a_rd_first, a_rd_last, a_rises, a_di_cnt, a_di_first, a_di_rises;
  int a_sop_cnt, a_eop_cnt, a_eop_syms, a_done_cnt, a_done_cyc, a_on_rise, a_on_fall;
  int a_err_cnt, a_err_cyc, a_busy_first, a_dat_bad;
  int a_rise [4];
  int b_rd_cnt, b_rises, b_done_cyc;
  int b_rise [4];
  logic a_prev_rd = 1'b0, a_prev_di = 1'b0, a_prev_on = 1'b0, b_prev_rd = 1'b0;
  logic [WIDTH-1:0] a_prev_re = '0, a_prev_im = '0;

  always @(negedge clk) begin
    if (clr) begin
      a_rd_cnt <= 0; a_rd_first <= -1; a_rd_last <= -1; a_rises <= 0;
      a_di_cnt <= 0; a_di_first <= -1; a_di_rises <= 0;
      a_sop_cnt <= 0; a_eop_cnt <= 0; a_eop_syms <= 0;
      a_done_cnt <= 0; a_done_cyc <= -1; a_on_rise <= -1; a_on_fall <= -1;
      a_err_cnt <= 0; a_err_cyc <= -1; a_busy_first <= -1; a_dat_bad <= 0;
      b_rd_cnt <= 0; b_rises <= 0; b_done_cyc <= -1;
      for (int i = 0; i < 4; i++) begin
        a_rise[i] <= -1;
        b_rise[i] <= -1;
      end
    end else begin
      if (a_rd_en) begin
        a_rd_cnt  <= a_rd_cnt + 1;
        a_rd_last <= cyc;
        if (a_rd_cnt == 0) a_rd_first <= cyc;
      end
      if (a_rd_en && !a_prev_rd) begin
        if (a_rises < 4) a_rise[a_rises] <= cyc;
        a_rises <= a_rises + 1;
      end
      if (a_di_en) begin
        a_di_cnt <= a_di_cnt + 1;
        if (a_di_cnt == 0) a_di_first <= cyc;
        if (a_di_re !== a_prev_re || a_di_im !== a_prev_im) a_dat_bad <= a_dat_bad + 1;
      end
      if (a_di_en && !a_prev_di) a_di_rises <= a_di_rises + 1;
      if (a_sop) a_sop_cnt <= a_sop_cnt + 1;
      if (a_eop) begin
        a_eop_cnt  <= a_eop_cnt + 1;
        a_eop_syms <= a_eop_syms * 4 + int'(a_sym);
      end
      if (a_done) begin
        a_done_cnt <= a_done_cnt + 1;
        a_done_cyc <= cyc;
      end
      if (a_fft_on && !a_prev_on) a_on_rise <= cyc;
      if (!a_fft_on && a_prev_on) a_on_fall <= cyc;
      if (a_err) begin
        a_err_cnt <= a_err_cnt + 1;
        a_err_cyc <= cyc;
      end
      if (a_busy && a_busy_first < 0) a_busy_first <= cyc;
      if (b_rd_en) b_rd_cnt <= b_rd_cnt + 1;
      if (b_rd_en && !b_prev_rd) begin
        if (b_rises < 4) b_rise[b_rises] <= cyc;
        b_rises <= b_rises + 1;
      end
      if (b_done) b_done_cyc <= cyc;
    end
    a_prev_rd <= a_rd_en;
    a_prev_di <= a_di_en;
    a_prev_on <= a_fft_on;
    a_prev_re <= buf_re;
    a_prev_im <= buf_im;
    b_prev_rd <= b_rd_en;
  end

  // ---------------------------------------------------------------- checking
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    clr = 1'b0;
  endtask

  // One slot with slot_start at cycle 5. frm_avail is low on [lo, hi).
  // A second slot_start arrives at 'stray'. At cycle 'mid' the block must
  // be holding WAIT with fft_on high.
  task automatic run_slot(input int lo, input int hi, input int stray, input int mid,
                          input int ncyc);
    clr        = 1'b1;
    cyc        = 0;
    slot_start = 1'b0;
    frm_avail  = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      step();
      slot_start = (cyc == 5) || (cyc == stray);
      frm_avail  = !(cyc >= lo && cyc < hi);
      buf_re     = WIDTH'(cyc * 37 + 5);
      buf_im     = ~buf_re;
      if (cyc == mid) begin
        check("starve_rd_en", int'(a_rd_en), 0);
        check("starve_fft_on", int'(a_fft_on), 1);
      end
    end
    slot_start = 1'b0;
  endtask

  task automatic check_a(input string s, input int rd_last, input int rise1,
                         input int rises, input int done_cyc);
    check({s, ":rd_first"}, a_rd_first, 7);
    check({s, ":rd_last"}, a_rd_last, rd_last);
    check({s, ":rd_cnt"}, a_rd_cnt, N * NSYM);
    check({s, ":rd_bursts"}, a_rises, rises);
    check({s, ":rise1"}, a_rise[1], rise1);
    check({s, ":di_first"}, a_di_first, 8);
    check({s, ":di_cnt"}, a_di_cnt, N * NSYM);
    check({s, ":di_bursts"}, a_di_rises, rises);
    check({s, ":di_data"}, a_dat_bad, 0);
    check({s, ":busy_rise"}, a_busy_first, 6);
    check({s, ":on_rise"}, a_on_rise, 6);
    check({s, ":sop_cnt"}, a_sop_cnt, 3);
    check({s, ":eop_cnt"}, a_eop_cnt, 3);
    check({s, ":eop_syms"}, a_eop_syms, 6);
    check({s, ":done_cnt"}, a_done_cnt, 1);
    check({s, ":done_cyc"}, a_done_cyc, done_cyc);
    check({s, ":on_fall"}, a_on_fall, done_cyc + 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", $countones(a_outs), 0);
    rst = 1'b1;

    // FFT output activity while idle must not be tagged.
    do_inject = 1'b1;
    step();
    check("idle_do_sop", int'(a_sop), 0);
    check("idle_do_eop", int'(a_eop), 0);
    step();
    do_inject = 1'b0;
    step();

    // Back-to-back slot, credit limit 2 and credit limit 1.
    run_slot(-1, -1, -1, -1, 130);
    check_a("b2b", 54, -1, 1, 67);
    check("b2b:err_cnt", a_err_cnt, 0);
    check("credit:rd_cnt", b_rd_cnt, N * NSYM);
    check("credit:bursts", b_rises, 3);
    check("credit:rise1", b_rise[1], 36);
    check("credit:rise2", b_rise[2], 65);
    check("credit:done_cyc", b_done_cyc, 93);

    // Buffer starvation between symbols 0 and 1, including a mid-burst drop.
    run_slot(15, 55, -1, 40, 130);
    check_a("starve", 87, 56, 2, 100);

    // Stray slot_start during STREAM.
    run_slot(-1, -1, 15, -1, 130);
    check_a("stray", 54, -1, 1, 67);
    check("stray:err_cnt", a_err_cnt, 1);
    check("stray:err_cyc", a_err_cyc, 16);

    // Burst start coincides with the first out_eop; credit must net to zero.
    run_slot(15, 34, -1, -1, 130);
    check_a("simul", 66, 35, 2, 79);

    // Asynchronous reset at burst cycle 7, then a full clean slot.
    clr        = 1'b1;
    cyc        = 0;
    frm_avail  = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      slot_start = (cyc == 5);
    end
    check("pre_reset_rd_en", int'(a_rd_en), 1);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", $countones(a_outs), 0);
    step();
    step();
    rst = 1'b1;
    run_slot(-1, -1, -1, -1, 130);
    check_a("post_rst", 54, -1, 1, 67);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Symbol-level scheduler sitting in front of the single-delay-feedback FFT pipeline in the PUSCH receive chain. It admits one slot of NSYM symbols, reads each N-sample symbol from the upstream first-word-fall-through (FWFT) sample buffer as a contiguous burst, and drives the FFT's `di_en`/`di_re`/`di_im`/`on` inputs. It also tags the FFT output stream with start/end-of-symbol and symbol index. The FFT cannot stall and its input counter restarts whenever `di_en` drops, so this block guarantees gap-free N-sample bursts and bounds the number of symbols in flight.

## Interface
- N, 128, FFT size; power of two, ≥4.
- NSYM, 14, symbols per slot; ≥1.
- MAX_INFLIGHT, 2, maximum symbols issued but not yet fully output; ≥1.
- WIDTH, 16, sample component width.

- clk  in  1  master clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- slot_start  in  1  one-cycle pulse that begins a slot.
- frm_avail  in  1  upstream buffer holds ≥N samples.
- buf_re / buf_im  in  WIDTH  FWFT buffer head sample, valid in the same cycle as rd_en.
- rd_en  out  1  buffer pop strobe.
- fft_on  out  1  drives FFT `on`.
- fft_di_en  out  1  drives FFT `di_en`.
- fft_di_re / fft_di_im  out  WIDTH  drive FFT data inputs.
- fft_do_en  in  1  FFT output enable.
- out_sop / out_eop  out  1  first / last output sample of a symbol.
- out_sym  out  clog2(NSYM)  symbol index of the current output sample.
- busy  out  1  high whenever the state is not IDLE.
- slot_done  out  1  one-cycle pulse when the last output sample of the slot has been seen.
- err  out  1  one-cycle pulse when slot_start arrives while busy.

## Operation
- States are IDLE, WAIT, STREAM, DRAIN.
- **IDLE:**
  - slot_start moves to WAIT.
  - Sym_issued, sym_out and out_cnt are cleared.
  - fft_on is set on the following cycle.
- **WAIT → STREAM** when all three hold: frm_avail=1, inflight<MAX_INFLIGHT, sym_issued<NSYM.
- **STREAM:**
  - rd_en=1 (combinational on state) for exactly N consecutive cycles; burst counter runs 0..N-1.
  - On the burst's first cycle: inflight+1.
  - On the last cycle: sym_issued+1.
  - If another symbol is admissible in that last cycle (same three WAIT conditions, evaluated with the updated counts), stay in STREAM back-to-back with no idle cycle.
  - Otherwise go to WAIT, or to DRAIN if sym_issued reaches NSYM.
- **DRAIN:**
  - Waits for the out_eop with sym_out==NSYM-1.
  - That cycle pulses slot_done; the next state is IDLE.
  - fft_on clears on the cycle after slot_done.
- **Input path:** fft_di_en, fft_di_re and fft_di_im are rd_en, buf_re and buf_im registered once.
- **Output tagging** (combinational on fft_do_en):
  - out_cnt advances on each fft_do_en and wraps N-1→0.
  - out_sop = fft_do_en && out_cnt==0.
  - out_eop = fft_do_en && out_cnt==N-1.
  - out_sym = sym_out; sym_out increments on out_eop.
  - out_eop decrements inflight.
  - If inflight increments and decrements in the same cycle, the net change is 0.
- **slot_start while busy:** ignored and pulses err; the slot in progress is unaffected.
- **fft_do_en in IDLE:** ignored; counters are not advanced.
- **Counter widths:** inflight uses clog2(MAX_INFLIGHT+1) bits and never exceeds MAX_INFLIGHT. sym_issued and sym_out use clog2(NSYM+1) bits.

## Timing
- **Reset values:** all outputs are 0 (rd_en, fft_on, fft_di_en, fft_di_re, fft_di_im, out_sop, out_eop, out_sym, busy, slot_done, err), the state is IDLE, and all counters are 0.
- **Reset mid-slot:** aborts immediately. Nothing is replayed, and the upstream buffer is not flushed by this block.
- **Start latency:** slot_start at cycle t gives busy=1 and fft_on=1 at t+1. With frm_avail already high, rd_en is first asserted at t+2 and fft_di_en at t+3.
- **Input burst:** fft_di_en lags rd_en by exactly 1 cycle and stays high for N contiguous cycles per symbol.
- **Back-to-back symbols:** produce 2N contiguous fft_di_en cycles.
- **frm_avail dropping mid-burst:** has no effect. The burst completes, because the buffer guaranteed N samples at admission.
- **Throughput:** one sample per clock. MAX_INFLIGHT=1 forces a gap of the FFT latency between symbols.

## Test plan
- **Single slot, back-to-back:** N=16, NSYM=3, frm_avail held high, slot_start at cycle 5.
  - rd_en high on cycles 7–54 with no gap.
  - 48 fft_di_en cycles.
  - out_sop ×3 and out_eop ×3, with out_sym = 0, 1, 2.
  - slot_done once; fft_on falls on the cycle after slot_done.
- **Credit stall:** MAX_INFLIGHT=1, frm_avail high.
  - The second burst starts only in the cycle after the first out_eop (WAIT is re-evaluated once inflight returns to 0).
  - inflight never exceeds 1.
- **Buffer starvation:** frm_avail low for 40 cycles between symbols 1 and 2.
  - The block holds WAIT with rd_en=0 and fft_on=1.
  - The burst starts 1 cycle after frm_avail rises.
- **Stray start:** slot_start pulsed while in STREAM.
  - err pulses 1 cycle; state and counters are unchanged.
  - Exactly NSYM symbols are still issued.
- **Reset mid-burst:** rst low at burst cycle 7.
  - All outputs are 0 within the same cycle (asynchronous).
  - After release the block is IDLE; a new slot_start runs a full, correct slot.
- **Simultaneous events:** a burst-start cycle coincides with out_eop.
  - inflight is unchanged.
  - Admission is still allowed at MAX_INFLIGHT-1.
